// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one single-port synchronous RAM between two requesters. Arbitration
// is combinational; the winning command is registered onto the RAM pins
// (stage 1). A read then raises a response flag one cycle later (stage 2),
// while the RAM is presenting the data, so a read accepted in cycle N is
// answered in cycle N+2. One command per cycle is sustained with no bubbles.
//
// Optional feature (compile-time macro):
//   RAM_ARB_ROUND_ROBIN_EN  defined   -> 1-bit round-robin pointer
//                                        resolves contention
//                           undefined -> requester 0 always wins contention
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid[1:0] per-requester command valid
//   req_ready[1:0] per-requester grant (at most one bit high)
//   req_we[1:0]    per-requester command type, 1 = write
//   req_addr       requester i address in [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata      requester i write data in [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid[1:0] one-cycle read-completion pulse, bit = owner
//   rsp_rdata      read data, valid while a rsp_valid bit is high
//   ram_address, ram_data_in, ram_we, ram_cs   registered RAM controls
//   ram_data_out   RAM read data
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   ram_address,
  output logic [DATA_WIDTH-1:0]   ram_data_in,
  output logic                    ram_we,
  output logic                    ram_cs,
  input  logic [DATA_WIDTH-1:0]   ram_data_out
);

  // Stage-1 (RAM command) registers
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [DATA_WIDTH-1:0] ram_data_in_q, ram_data_in_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_cs_q, ram_cs_d;
  logic                  s1_owner_q, s1_owner_d;
  logic                  s1_rd_q, s1_rd_d;

  // Stage-2 (response) registers
  logic                  rsp_pend_q, rsp_pend_d;
  logic                  rsp_owner_q, rsp_owner_d;

  // Requester favoured on contention
  logic                  favour;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic                  ptr_q, ptr_d;
  assign favour = ptr_q;
`else
  assign favour = 1'b0;
`endif

  logic [1:0]            gnt;
  logic                  accept;
  logic                  sel;

  // Combinational grant; nothing is granted while reset is asserted.
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      case (req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = favour ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign sel       = gnt[1];

  // Stage-1 next state: load on accept, otherwise deselect the RAM but keep
  // address/data stable.
  always_comb begin
    ram_cs_d      = accept;
    ram_we_d      = 1'b0;
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;
    s1_owner_d    = s1_owner_q;
    s1_rd_d       = 1'b0;
    if (accept) begin
      ram_we_d      = sel ? req_we[1] : req_we[0];
      ram_address_d = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
      ram_data_in_d = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
      s1_owner_d    = sel;
      s1_rd_d       = ~ram_we_d;
    end
  end

  // Stage-2 next state: a stage-1 read becomes a pending response while the
  // RAM captures its data.
  always_comb begin
    rsp_pend_d  = s1_rd_q;
    rsp_owner_d = s1_rd_q ? s1_owner_q : rsp_owner_q;
  end

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Any grant hands priority to the other requester.
  always_comb begin
    ptr_d = accept ? ~sel : ptr_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      ram_we_q      <= 1'b0;
      ram_cs_q      <= 1'b0;
      s1_owner_q    <= 1'b0;
      s1_rd_q       <= 1'b0;
      rsp_pend_q    <= 1'b0;
      rsp_owner_q   <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      ptr_q         <= 1'b0;
`endif
    end else begin
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
      ram_we_q      <= ram_we_d;
      ram_cs_q      <= ram_cs_d;
      s1_owner_q    <= s1_owner_d;
      s1_rd_q       <= s1_rd_d;
      rsp_pend_q    <= rsp_pend_d;
      rsp_owner_q   <= rsp_owner_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

  assign ram_address = ram_address_q;
  assign ram_data_in = ram_data_in_q;
  assign ram_we      = ram_we_q;
  assign ram_cs      = ram_cs_q;

  assign rsp_valid   = {rsp_pend_q & rsp_owner_q, rsp_pend_q & ~rsp_owner_q};
  // RAM output is already registered inside the RAM; pass it straight through.
  assign rsp_rdata   = ram_data_out;

endmodule
